mem_arbiter: RTL and testbench

- Parametrised memory front-end between N pipeline request channels (ch0 = instruction fetch, ch1 = data load/store, more for future masters) and one shared RAM helper port.
- Arbitrates round-robin with a valid/ready request handshake and one outstanding transaction at a time.
- Aligns store data and byte masks; right-aligns load data; returns a one-cycle response pulse after a configurable RAM read latency.
- Replaces the fixed dual-port, zero-wait memory hookup at the top level and enables variable-latency memory behind the pipeline's stall logic.

---
 rtl/mem_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: round-robin N-channel front-end onto one shared RAM port.
// Define MEM_ARB_PERF_EN to add per-channel grant and wait counters.
module mem_arbiter #(
  parameter int          CH_NUM    = 2,
  parameter int          ADDR_W    = 64,
  parameter int          RAM_LAT   = 1,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CH_NUM-1:0]          req_valid,
  output logic [CH_NUM-1:0]          req_ready,
  input  logic [CH_NUM-1:0]          req_wen,
  input  logic [CH_NUM*ADDR_W-1:0]   req_addr,
  input  logic [CH_NUM*2-1:0]        req_size,
  input  logic [CH_NUM*64-1:0]       req_wdata,
  output logic [CH_NUM-1:0]          rsp_valid,
  output logic [CH_NUM-1:0]          rsp_err,
  output logic [CH_NUM*64-1:0]       rsp_rdata,
  output logic                       ram_en,
  output logic [63:0]                ram_ridx,
  input  logic [63:0]                ram_rdata,
  output logic                       ram_wen,
  output logic [63:0]                ram_widx,
  output logic [63:0]                ram_wdata,
  output logic [63:0]                ram_wmask,
  output logic                       busy
`ifdef MEM_ARB_PERF_EN
  ,
  input  logic                       perf_clr,
  output logic [CH_NUM*32-1:0]       perf_grant_cnt,
  output logic [31:0]                perf_wait_cnt
`endif
);

  localparam int IW    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int WLAST = (RAM_LAT > 1) ? RAM_LAT - 2 : 0;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t state, state_d;

  logic [IW-1:0]     rr_ptr, win, owner, owner_d;
  logic              found, grant, mis;
  logic              sel_wen;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [63:0]       sel_wdata;
  int                scan_j;

  logic              l_wen, l_err;
  logic [2:0]        l_off;
  logic [1:0]        wait_cnt;

  logic              ram_en_d, ram_wen_d;
  logic [63:0]       ridx_d, widx_d, wdata_d, wmask_d, idx_d;
  logic [7:0]        bmask;
  logic [CH_NUM-1:0] rsp_v_d, rsp_e_d;

  function automatic logic [2:0] lo_mask(input logic [1:0] s);
    unique case (s)
      2'd0: return 3'b000;
      2'd1: return 3'b001;
      2'd2: return 3'b011;
      2'd3: return 3'b111;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] s);
    unique case (s)
      2'd0: return 8'h01;
      2'd1: return 8'h03;
      2'd2: return 8'h0F;
      2'd3: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] byte_expand(input logic [7:0] m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  // Scan starts at rr_ptr and wraps; first valid channel wins.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    scan_j    = 0;
    sel_wen   = 1'b0;
    sel_size  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      scan_j = int'(rr_ptr) + k;
      if (scan_j >= CH_NUM) scan_j = scan_j - CH_NUM;
      if (!found && req_valid[scan_j]) begin
        found     = 1'b1;
        win       = IW'(scan_j);
        sel_wen   = req_wen[scan_j];
        sel_size  = req_size[2*scan_j +: 2];
        sel_addr  = req_addr[scan_j*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[64*scan_j +: 64];
      end
    end
  end

  assign grant   = rst && (state == IDLE) && found;
  assign mis     = |(sel_addr[2:0] & lo_mask(sel_size));
  assign owner_d = grant ? win : owner;
  assign busy    = (state != IDLE);

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (grant) state_d = mis ? RESP : ISSUE;
      ISSUE: state_d = (l_wen || RAM_LAT == 1) ? RESP : WAIT;
      WAIT:  if (wait_cnt == 2'(WLAST)) state_d = RESP;
      RESP:  state_d = IDLE;
    endcase
  end

  // Next values for the registered RAM and response outputs.
  always_comb begin
    ram_en_d  = 1'b0;
    ram_wen_d = 1'b0;
    idx_d     = (64'(sel_addr) - BASE_ADDR) >> 3;
    bmask     = size_mask(sel_size) << sel_addr[2:0];
    ridx_d    = '0;
    widx_d    = '0;
    wdata_d   = '0;
    wmask_d   = '0;
    rsp_v_d   = '0;
    rsp_e_d   = '0;
    if (grant && !mis) begin
      if (sel_wen) begin
        ram_wen_d = 1'b1;
        widx_d    = idx_d;
        wdata_d   = sel_wdata << {sel_addr[2:0], 3'b000};
        wmask_d   = byte_expand(bmask);
      end else begin
        ram_en_d = 1'b1;
        ridx_d   = idx_d;
      end
    end
    if (state_d == RESP) begin
      rsp_v_d[owner_d] = 1'b1;
      rsp_e_d[owner_d] = (state == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      l_wen     <= 1'b0;
      l_err     <= 1'b0;
      l_off     <= '0;
      wait_cnt  <= '0;
      ram_en    <= 1'b0;
      ram_wen   <= 1'b0;
      ram_ridx  <= '0;
      ram_widx  <= '0;
      ram_wdata <= '0;
      ram_wmask <= '0;
      rsp_valid <= '0;
      rsp_err   <= '0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      wait_cnt  <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
      ram_en    <= ram_en_d;
      ram_wen   <= ram_wen_d;
      ram_ridx  <= ridx_d;
      ram_widx  <= widx_d;
      ram_wdata <= wdata_d;
      ram_wmask <= wmask_d;
      rsp_valid <= rsp_v_d;
      rsp_err   <= rsp_e_d;
      if (grant) begin
        rr_ptr <= (win == IW'(CH_NUM - 1)) ? '0 : win + 1'b1;
        l_wen  <= sel_wen;
        l_err  <= mis;
        l_off  <= sel_addr[2:0];
      end
    end
  end

  // Load data arrives in the RESP cycle itself, so it bypasses the flops.
  always_comb begin
    rsp_rdata = '0;
    if (state == RESP && !l_wen && !l_err) begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (owner == IW'(k))
          rsp_rdata[64*k +: 64] = ram_rdata >> {l_off, 3'b000};
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic        any_wait;
  logic [31:0] gcnt [CH_NUM];

  assign any_wait = (|req_valid) && !(|req_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perf_wait_cnt <= '0;
    else if (perf_clr)
      perf_wait_cnt <= '0;
    else if (any_wait && perf_wait_cnt != '1)
      perf_wait_cnt <= perf_wait_cnt + 32'd1;
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_perf
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        gcnt[g] <= '0;
      else if (perf_clr)
        gcnt[g] <= '0;
      else if (req_ready[g] && gcnt[g] != '1)
        gcnt[g] <= gcnt[g] + 32'd1;
    end
    assign perf_grant_cnt[32*g +: 32] = gcnt[g];
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// tb_mem_arbiter: scoreboard bench, RAM_LAT=1 and RAM_LAT=3 instances.
// Expected responses and RAM ops are queued at handshake, checked by monitors.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    logic        err;
    logic [63:0] rdata;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic        wen;
    logic [63:0] idx;
    logic [63:0] wd;
    logic [63:0] wm;
    int          cyc;
  } ram_t;

  rsp_t rq0[$], rq1[$];
  ram_t mq0[$], mq1[$];

  logic        v  [2][2];
  logic        w  [2][2];
  logic [63:0] a  [2][2];
  logic [1:0]  s  [2][2];
  logic [63:0] wd [2][2];

  logic [1:0]   rv0, rw0, rdy0, rspv0, rspe0;
  logic [127:0] ra0, rwd0, rsprd0;
  logic [3:0]   rs0;
  logic         en0, wen0, busy0;
  logic [63:0]  ridx0, widx0, rdat0, wdat0, wmask0;

  logic [1:0]   rv1, rw1, rdy1, rspv1, rspe1;
  logic [127:0] ra1, rwd1, rsprd1;
  logic [3:0]   rs1;
  logic         en1, wen1, busy1;
  logic [63:0]  ridx1, widx1, rdat1, wdat1, wmask1;

  assign rv0  = {v[0][1], v[0][0]};
  assign rw0  = {w[0][1], w[0][0]};
  assign ra0  = {a[0][1], a[0][0]};
  assign rs0  = {s[0][1], s[0][0]};
  assign rwd0 = {wd[0][1], wd[0][0]};
  assign rv1  = {v[1][1], v[1][0]};
  assign rw1  = {w[1][1], w[1][0]};
  assign ra1  = {a[1][1], a[1][0]};
  assign rs1  = {s[1][1], s[1][0]};
  assign rwd1 = {wd[1][1], wd[1][0]};

  mem_arbiter #(.RAM_LAT(1)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(rv0), .req_ready(rdy0), .req_wen(rw0),
    .req_addr(ra0), .req_size(rs0), .req_wdata(rwd0),
    .rsp_valid(rspv0), .rsp_err(rspe0), .rsp_rdata(rsprd0),
    .ram_en(en0), .ram_ridx(ridx0), .ram_rdata(rdat0),
    .ram_wen(wen0), .ram_widx(widx0), .ram_wdata(wdat0),
    .ram_wmask(wmask0), .busy(busy0)
  );

  mem_arbiter #(.RAM_LAT(3)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(rv1), .req_ready(rdy1), .req_wen(rw1),
    .req_addr(ra1), .req_size(rs1), .req_wdata(rwd1),
    .rsp_valid(rspv1), .rsp_err(rspe1), .rsp_rdata(rsprd1),
    .ram_en(en1), .ram_ridx(ridx1), .ram_rdata(rdat1),
    .ram_wen(wen1), .ram_widx(widx1), .ram_wdata(wdat1),
    .ram_wmask(wmask1), .busy(busy1)
  );

  // RAM models: read data valid RAM_LAT cycles after ram_en.
  logic [63:0] mem [16];
  logic [63:0] p1, p2;
  always @(posedge clk) begin
    rdat0 <= mem[ridx0[3:0]];
    p1    <= mem[ridx1[3:0]];
    p2    <= p1;
    rdat1 <= p2;
  end

  function automatic void chk(input string nm, input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic void chk_rsp(input string p, input rsp_t e,
                                  input logic [1:0] vv, input logic [1:0] ee,
                                  input logic [127:0] rd);
    logic [1:0] m;
    m = 2'b01 << e.ch;
    chk({p, "_cyc"}, 64'(cyc), 64'(e.cyc));
    chk({p, "_ch"}, 64'(vv), 64'(m));
    chk({p, "_err"}, 64'(ee), 64'(e.err ? m : 2'b00));
    chk({p, "_rdata"}, rd[e.ch*64 +: 64], e.rdata);
  endfunction

  function automatic void chk_ram(input string p, input ram_t e,
                                  input logic en, input logic wen,
                                  input logic [63:0] ri, input logic [63:0] wi,
                                  input logic [63:0] wdt, input logic [63:0] wm);
    chk({p, "_cyc"}, 64'(cyc), 64'(e.cyc));
    chk({p, "_op"}, 64'({en, wen}), 64'(e.wen ? 2'b01 : 2'b10));
    chk({p, "_idx"}, e.wen ? wi : ri, e.idx);
    chk({p, "_wdata"}, wdt, e.wd);
    chk({p, "_wmask"}, wm, e.wm);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (|rspv0) begin
        if (rq0.size() == 0) chk("rsp0_extra", 64'(rspv0), 64'd0);
        else chk_rsp("rsp0", rq0.pop_front(), rspv0, rspe0, rsprd0);
      end
      if (|rspv1) begin
        if (rq1.size() == 0) chk("rsp1_extra", 64'(rspv1), 64'd0);
        else chk_rsp("rsp1", rq1.pop_front(), rspv1, rspe1, rsprd1);
      end
      if (en0 || wen0) begin
        if (mq0.size() == 0) chk("ram0_extra", 64'({en0, wen0}), 64'd0);
        else chk_ram("ram0", mq0.pop_front(), en0, wen0, ridx0, widx0, wdat0, wmask0);
      end
      if (en1 || wen1) begin
        if (mq1.size() == 0) chk("ram1_extra", 64'({en1, wen1}), 64'd0);
        else chk_ram("ram1", mq1.pop_front(), en1, wen1, ridx1, widx1, wdat1, wmask1);
      end
    end
  end

  function automatic logic rdy(input int d, input int ch);
    return (d == 0) ? rdy0[ch] : rdy1[ch];
  endfunction

  task automatic issue(input int d, input int ch, input logic wen,
                       input logic [63:0] addr, input logic [1:0] sz,
                       input logic [63:0] wdt, input logic err,
                       input logic [63:0] erd, input logic [63:0] eidx,
                       input logic [63:0] ewd, input logic [63:0] ewm,
                       input bit push, output int tc);
    int   n;
    int   lat;
    rsp_t r;
    ram_t m;
    lat = (d == 0) ? 1 : 3;
    tc  = -1;
    n   = 0;
    v[d][ch]  = 1'b1;
    w[d][ch]  = wen;
    a[d][ch]  = addr;
    s[d][ch]  = sz;
    wd[d][ch] = wdt;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy(d, ch) && n < 60);
    if (!rdy(d, ch)) begin
      total++;
      bad++;
      $display("FAIL grant_timeout d%0d ch%0d: got ready=0 want 1", d, ch);
      v[d][ch] = 1'b0;
      return;
    end
    tc = cyc;
    if (push) begin
      r.ch    = ch;
      r.err   = err;
      r.rdata = erd;
      r.cyc   = cyc + (err ? 1 : (wen ? 2 : 1 + lat));
      if (d == 0) rq0.push_back(r);
      else rq1.push_back(r);
    end
    if (!err) begin
      m.wen = wen;
      m.idx = eidx;
      m.wd  = ewd;
      m.wm  = ewm;
      m.cyc = cyc + 1;
      if (d == 0) mq0.push_back(m);
      else mq1.push_back(m);
    end
    @(posedge clk);
    #1;
    v[d][ch] = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] M0  = 64'hDEAD_BEEF_00C0_FFEE;
  localparam logic [63:0] M1  = 64'h1122_3344_5566_7788;
  localparam logic [63:0] M15 = 64'h0F0E_0D0C_0B0A_0908;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int t0a, t0b, t1a, t1b, tc;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        v[d][c] = 1'b0; w[d][c] = 1'b0; a[d][c] = '0;
        s[d][c] = '0; wd[d][c] = '0;
      end
    for (int i = 0; i < 16; i++) mem[i] = 64'(i) * 64'h0101;
    mem[0]  = M0;
    mem[1]  = M1;
    mem[15] = M15;

    v[0][0] = 1'b1;
    v[0][1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(rdy0), 64'd0);
    chk("rst_rsp", 64'({rspv0, rspe0}), 64'd0);
    chk("rst_rdata", rsprd0[63:0] | rsprd0[127:64], 64'd0);
    chk("rst_ram", 64'({en0, wen0, busy0}), 64'd0);
    chk("rst_ram_bus", ridx0 | widx0 | wdat0 | wmask0, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    fork
      begin
        issue(0, 0, 0, 64'h8000_0000, 3, 0, 0, M0, 0, 0, 0, 1, t0a);
        issue(0, 0, 0, 64'h8000_0000, 3, 0, 0, M0, 0, 0, 0, 1, t0b);
      end
      begin
        issue(0, 1, 0, 64'h8000_0008, 3, 0, 0, M1, 1, 0, 0, 1, t1a);
        issue(0, 1, 0, 64'h8000_0008, 3, 0, 0, M1, 1, 0, 0, 1, t1b);
      end
    join
    chk("rr_ch1_first", 64'(t1a - t0a), 64'd3);
    chk("rr_ch0_second", 64'(t0b - t0a), 64'd6);
    chk("rr_ch1_second", 64'(t1b - t0a), 64'd9);
    settle(4);

    issue(0, 1, 0, 64'h8000_0008, 3, 0, 0, M1, 1, 0, 0, 1, tc);
    settle(4);
    issue(0, 1, 1, 64'h8000_0013, 0, 64'hAB, 0, 0, 2,
          64'hAB00_0000, 64'h0000_0000_FF00_0000, 1, tc);
    settle(4);
    issue(0, 0, 1, 64'h8000_000A, 1, 64'h1234, 0, 0, 1,
          64'h1234_0000, 64'h0000_0000_FFFF_0000, 1, tc);
    settle(4);
    issue(0, 0, 0, 64'h8000_0009, 0, 0, 0, 64'h0011_2233_4455_6677, 1, 0, 0, 1, tc);
    settle(4);
    issue(0, 1, 0, 64'h8000_000E, 1, 0, 0, 64'h0000_0000_0000_1122, 1, 0, 0, 1, tc);
    settle(4);
    issue(0, 1, 0, 64'h8000_0006, 2, 0, 1, 0, 0, 0, 0, 1, tc);
    settle(4);
    issue(0, 0, 1, 64'h8000_0001, 3, 64'h55, 1, 0, 0, 0, 0, 1, tc);
    settle(4);
    issue(0, 0, 0, 64'h7FFF_FFF8, 3, 0, 0, M15, 64'h1FFF_FFFF_FFFF_FFFF, 0, 0, 1, tc);
    settle(4);

    issue(1, 0, 0, 64'h8000_0004, 2, 0, 0, 64'h0000_0000_DEAD_BEEF, 0, 0, 0, 1, tc);
    for (int i = 0; i < 4; i++) begin
      chk("lat_busy_on", 64'(busy1), 64'd1);
      @(posedge clk);
      #1;
    end
    chk("lat_busy_off", 64'(busy1), 64'd0);
    settle(3);

    issue(1, 0, 0, 64'h8000_0008, 3, 0, 0, M1, 1, 0, 0, 0, tc);
    @(posedge clk);
    #1;
    chk("wait_busy", 64'(busy1), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_busy", 64'({busy1, en1, wen1}), 64'd0);
    chk("arst_rsp", 64'({rspv1, rspe1}), 64'd0);
    chk("arst_rdata", rsprd1[63:0] | rsprd1[127:64], 64'd0);
    settle(2);
    rst = 1'b1;
    settle(6);

    fork
      issue(1, 0, 0, 64'h8000_0000, 3, 0, 0, M0, 0, 0, 0, 1, t0a);
      issue(1, 1, 0, 64'h8000_0008, 3, 0, 0, M1, 1, 0, 0, 1, t1a);
    join
    chk("rr_after_rst", 64'(t1a - t0a), 64'd5);
    settle(8);

    chk("rsp_left", 64'(rq0.size() + rq1.size()), 64'd0);
    chk("ram_left", 64'(mq0.size() + mq1.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
